// File: rtl/q2fsm_pkg.sv
// Shared types and next-state/output functions for the time-multiplexed
// 2012-Q2 sequence detector (states A..F, z=1 in E/F).
package q2fsm_pkg;

    typedef enum logic [2:0] {
        ST_A = 3'd0,
        ST_B = 3'd1,
        ST_C = 3'd2,
        ST_D = 3'd3,
        ST_E = 3'd4,
        ST_F = 3'd5
    } q2_state_t;

    localparam int ARB_RR = 0;
    localparam int ARB_FP = 1;

    // Unused encodings 6/7 fall back to A so a corrupted entry self-heals.
    function automatic q2_state_t q2_next(input q2_state_t s, input logic w);
        case (s)
            ST_A:    return w ? ST_B : ST_A;
            ST_B:    return w ? ST_C : ST_D;
            ST_C:    return w ? ST_E : ST_D;
            ST_D:    return w ? ST_F : ST_A;
            ST_E:    return w ? ST_E : ST_D;
            ST_F:    return w ? ST_C : ST_D;
            default: return ST_A;
        endcase
    endfunction

    function automatic logic q2_z(input q2_state_t s);
        return (s == ST_E) || (s == ST_F);
    endfunction

endpackage

// File: rtl/q2fsm_next_state.sv
// Shared combinational next-state engine; fed with whichever channel won
// arbitration this cycle.
module q2fsm_next_state
    import q2fsm_pkg::*;
(
    input  q2_state_t i_state,
    input  logic      i_w,
    output q2_state_t o_next,
    output logic      o_z
);

    assign o_next = q2_next(i_state, i_w);
    assign o_z    = q2_z(o_next);

endmodule

// File: rtl/q2fsm_channel_scheduler.sv
// Per-channel state file plus a one-grant-per-cycle arbiter sharing a single
// q2 next-state engine across NUM_CH serial w-streams.
module q2fsm_channel_scheduler
    import q2fsm_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int ARB_MODE = ARB_RR,
    localparam int CW       = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req_valid,
    input  logic [NUM_CH-1:0] req_w,
    output logic [NUM_CH-1:0] req_ready,
    input  logic [NUM_CH-1:0] ch_clear,
    output logic              out_valid,
    output logic [CW-1:0]     out_chan,
    output logic [2:0]        out_state,
    output logic              out_z,
    output logic [NUM_CH-1:0] z_vec
);

    q2_state_t         r_state [NUM_CH];
    logic [CW-1:0]     r_rr_ptr;
    logic              r_out_valid;
    logic [CW-1:0]     r_out_chan;
    q2_state_t         r_out_state;
    logic              r_out_z;

    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_grant;
    logic [CW-1:0]     w_start;
    logic [CW:0]       w_idx;
    logic [CW-1:0]     w_gnt_idx;
    logic              w_any;
    q2_state_t         w_cur_state;
    logic              w_cur_w;
    q2_state_t         w_next_state;
    logic              w_next_z;

    // A clear masks the channel out of arbitration; it never consumes a sample.
    assign w_elig = req_valid & ~ch_clear;

    // Rotating search from the start index; fixed priority simply starts at 0.
    always_comb begin
        w_start   = (ARB_MODE == ARB_RR) ? r_rr_ptr : '0;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = {1'b0, w_start} + (CW+1)'(k);
            if (w_idx >= (CW+1)'(NUM_CH))
                w_idx = w_idx - (CW+1)'(NUM_CH);
            if (!w_any && w_elig[w_idx[CW-1:0]]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_idx[CW-1:0];
            end
        end
    end

    assign w_grant   = w_any ? (NUM_CH'(1) << w_gnt_idx) : '0;
    assign req_ready = reset ? w_grant : '0;

    assign w_cur_state = r_state[w_gnt_idx];
    assign w_cur_w     = req_w[w_gnt_idx];

    q2fsm_next_state u_next (
        .i_state (w_cur_state),
        .i_w     (w_cur_w),
        .o_next  (w_next_state),
        .o_z     (w_next_z)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++)
                r_state[i] <= ST_A;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clear[i])
                    r_state[i] <= ST_A;
                else if (w_grant[i])
                    r_state[i] <= w_next_state;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (ARB_MODE == ARB_RR && w_any) begin
            r_rr_ptr <= (w_gnt_idx == CW'(NUM_CH-1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Payload holds its last value on idle cycles; only valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
            r_out_state <= ST_A;
            r_out_z     <= 1'b0;
        end else begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_chan  <= w_gnt_idx;
                r_out_state <= w_next_state;
                r_out_z     <= w_next_z;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;
    assign out_state = r_out_state;
    assign out_z     = r_out_z;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_zvec
        assign z_vec[i] = q2_z(r_state[i]);
    end

endmodule

// File: tb/tb_q2fsm_channel_scheduler.sv
// Directed bench with a reference model and an output scoreboard queue for
// q2fsm_channel_scheduler (NUM_CH=4, round-robin).
module tb_q2fsm_channel_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid, req_w, ch_clear;
    logic [3:0] req_ready;
    logic       out_valid;
    logic [1:0] out_chan;
    logic [2:0] out_state;
    logic       out_z;
    logic [3:0] z_vec;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       vld;
        logic [1:0] chan;
        logic [2:0] st;
        logic       z;
    } exp_t;

    exp_t sb[$];

    int         m_st [4];
    int         m_ptr;
    logic [1:0] m_chan;
    logic [2:0] m_ostate;
    logic       m_oz;
    int         gcnt [4];
    int         glast;

    q2fsm_channel_scheduler #(.NUM_CH(4), .ARB_MODE(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_w     (req_w),
        .req_ready (req_ready),
        .ch_clear  (ch_clear),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .out_state (out_state),
        .out_z     (out_z),
        .z_vec     (z_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Detector table written out directly from the state diagram.
    function automatic int mnext(input int s, input logic w);
        int t1 [6] = '{1, 2, 4, 5, 4, 2};
        int t0 [6] = '{0, 3, 3, 0, 3, 3};
        if (s < 0 || s > 5) return 0;
        return w ? t1[s] : t0[s];
    endfunction

    function automatic logic [3:0] mzvec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (m_st[i] == 4 || m_st[i] == 5);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_st[i] = 0;
        m_ptr = 0; m_chan = 0; m_ostate = 0; m_oz = 0;
    endtask

    // Called just after a negedge: drive, predict, clock, compare.
    task automatic step(input string tag, input logic [3:0] v, input logic [3:0] w, input logic [3:0] c);
        int   g;
        int   idx;
        int   ns;
        exp_t e;
        exp_t got;
        req_valid = v; req_w = w; ch_clear = c;
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (g < 0 && v[idx] && !c[idx]) g = idx;
        end
        check({tag, ".ready"}, req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) begin
            ns = mnext(m_st[g], w[g]);
            m_st[g]  = ns;
            m_chan   = 2'(g);
            m_ostate = 3'(ns);
            m_oz     = (ns == 4 || ns == 5);
            m_ptr    = (g == 3) ? 0 : g + 1;
            gcnt[g]++;
        end
        glast = g;
        for (int i = 0; i < 4; i++) if (c[i]) m_st[i] = 0;
        e.vld = (g >= 0); e.chan = m_chan; e.st = m_ostate; e.z = m_oz;
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check({tag, ".out_valid"}, out_valid, got.vld);
            check({tag, ".out_chan"},  out_chan,  got.chan);
            check({tag, ".out_state"}, out_state, got.st);
            check({tag, ".out_z"},     out_z,     got.z);
        end
        check({tag, ".z_vec"}, z_vec, mzvec());
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; req_valid = 4'hF; req_w = 4'h0; ch_clear = 4'h0;
        model_reset();
        for (int i = 0; i < 4; i++) gcnt[i] = 0;

        // 1: reset holds everything idle even with all channels requesting
        #3;
        check("rst.ready", req_ready, 4'h0);
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.z_vec", z_vec, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.hold_valid", out_valid, 1'b0);
        check("rst.hold_ready", req_ready, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        step("t1.first", 4'hF, 4'h0, 4'h0);
        check("t1.first_chan", out_chan, 2'd0);

        // 2: ch0 alone, w=1,1,1 -> B,C,E
        step("t2.s1", 4'h1, 4'h1, 4'h0);
        step("t2.s2", 4'h1, 4'h1, 4'h0);
        step("t2.s3", 4'h1, 4'h1, 4'h0);
        check("t2.state_E", out_state, 3'd4);
        check("t2.zvec0", z_vec[0], 1'b1);

        // 3: ch1 alone, w=1,0,1 -> B,D,F then w=0 -> D
        step("t3.s1", 4'h2, 4'h2, 4'h0);
        step("t3.s2", 4'h2, 4'h0, 4'h0);
        step("t3.s3", 4'h2, 4'h2, 4'h0);
        check("t3.state_F", out_state, 3'd5);
        step("t3.s4", 4'h2, 4'h0, 4'h0);
        check("t3.state_D", out_state, 3'd3);

        // 4: fairness from a fresh pointer
        @(negedge clk); reset = 1'b0; model_reset();
        #1; @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 4; i++) gcnt[i] = 0;
        for (int k = 0; k < 8; k++) begin
            step("t4.rr", 4'hF, 4'($urandom_range(0, 15)), 4'h0);
            check("t4.order", 32'(glast), 32'(k % 4));
        end
        for (int i = 0; i < 4; i++) check("t4.twice", 32'(gcnt[i]), 32'd2);

        // 5: clear beats a pending request on the same channel
        step("t5.clr", 4'h0, 4'h0, 4'h4);
        step("t5.w1", 4'h4, 4'h4, 4'h0);
        step("t5.w2", 4'h4, 4'h4, 4'h0);
        step("t5.w3", 4'h4, 4'h4, 4'h0);
        check("t5.zvec2_set", z_vec[2], 1'b1);
        step("t5.clr_only", 4'h4, 4'h4, 4'h4);
        check("t5.zvec2_clr", z_vec[2], 1'b0);
        step("t5.clr_other", 4'h5, 4'h5, 4'h4);
        check("t5.other_chan", out_chan, 2'd0);

        // 6: async reset inside a grant cycle
        req_valid = 4'hF; req_w = 4'hF; ch_clear = 4'h0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("t6.ready", req_ready, 4'h0);
        check("t6.out_valid", out_valid, 1'b0);
        check("t6.z_vec", z_vec, 4'h0);
        @(posedge clk); #1;
        check("t6.no_valid", out_valid, 1'b0);
        @(negedge clk); reset = 1'b1;
        step("t6.idle", 4'h0, 4'h0, 4'h0);
        step("t6.restart", 4'hF, 4'hF, 4'h0);
        check("t6.chan0", out_chan, 2'd0);
        check("t6.state_B", out_state, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
